// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and transmitter.
//   - ST_IDLE/ST_START/ST_DATA/ST_STOP : 2-bit FSM state encodings
//   - bit_period()                     : clk cycles per bit for a given clock and baud
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int bit_period(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for an asynchronous single-bit input.
//   Both flops reset to RESET_VAL so the output does not glitch after reset.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   d     in  asynchronous input
//   q     out synchronised output (two clk of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receiver, LSB first. Synchronises rx, qualifies the start bit on
//   a falling edge, samples every bit at mid-period and presents the byte with
//   a single-cycle strobe.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   rx           in   asynchronous serial line, idle high
//   data_out     out  last correctly framed byte, held until the next good frame
//   valid        out  one-cycle pulse: data_out updated
//   frame_error  out  one-cycle pulse: stop bit sampled low, data_out unchanged
//   busy         out  high from start-edge detect until the stop-bit sample
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a falling edge on the synchronised line
// ST_START | half a bit into the start bit; confirm it is still low
// ST_DATA  | sampling the eight data bits at mid-bit
// ST_STOP  | sampling the stop bit; strobe valid or frame_error
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9_600,
  parameter int CLOCK_FREQ = 48_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int BIT_PERIOD  = bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int TIMER_W     = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(BIT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(HALF_PERIOD - 1);

  logic               rx_s;
  logic               rx_prev;
  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         bit_index;
  logic [7:0]         shift_reg;
  logic               fall_edge;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign fall_edge = rx_prev & ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev     <= 1'b1;
      state       <= ST_IDLE;
      timer       <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      valid       <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Edge-qualified start: a line held low (break) cannot restart a frame.
          if (fall_edge) begin
            timer <= HALF_LOAD;
            busy  <= 1'b1;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (timer == '0) begin
            if (!rx_s) begin
              bit_index <= '0;
              timer     <= BIT_LOAD;
              state     <= ST_DATA;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        ST_DATA: begin
          if (timer == '0) begin
            shift_reg[bit_index] <= rx_s;
            timer                <= BIT_LOAD;
            if (bit_index == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        ST_STOP: begin
          if (timer == '0) begin
            if (rx_s) begin
              data_out <= shift_reg;
              valid    <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            // Returning to idle at mid-stop-bit leaves half a bit to catch
            // a start bit that follows with no idle gap.
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Self-checking bench for uart_receiver at BIT_PERIOD = 10 clk.
//   A behavioural serialiser drives rx; a monitor logs every strobe with its
//   cycle number, and each test compares that log against the frames it sent.
module tb_uart_receiver;

  localparam int CLK_F = 1_000_000;
  localparam int BAUD  = 100_000;
  localparam int BITP  = CLK_F / BAUD;
  // rx fall -> 2 sync flops + edge detect (3 clk), half bit to start sample,
  // then 8 data bits and the stop bit one full bit apart each.
  localparam int LATENCY = 3 + (BITP / 2) + 9 * BITP;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_error;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] last_good;

  uart_receiver #(
    .BAUD_RATE  (BAUD),
    .CLOCK_FREQ (CLK_F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && (valid || frame_error)) begin
      n_cmp++;
      if (valid && frame_error) begin
        n_fail++;
        $display("FAIL strobe_exclusive: valid=%b frame_error=%b, required only one", valid, frame_error);
      end
      evq.push_back('{is_err: frame_error, data: data_out, cyc: cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    rx = 1'b0;
    t0 = cyc;
    repeat (BITP) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITP) tick();
    end
    rx = stop;
    repeat (BITP) tick();
  endtask

  task automatic wait_events(input int n, input int budget);
    int k = 0;
    while (evq.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (2 * BITP) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    last_good = 8'h00;
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b[$];
    int         exp_t[$];
    int         t0;
    evq.delete();
    exp_b.push_back(8'h55);
    exp_b.push_back(8'hA5);
    for (int i = 0; i < 6; i++) exp_b.push_back(8'($urandom_range(0, 255)));
    foreach (exp_b[i]) begin
      send_frame(exp_b[i], 1'b1, t0);
      exp_t.push_back(t0);
      repeat ($urandom_range(0, 15)) tick();
    end
    wait_events(exp_b.size(), 300);
    n_cmp++;
    if (evq.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL loop_count: got %0d strobes want %0d", evq.size(), exp_b.size());
    end else begin
      foreach (exp_b[i]) begin
        n_cmp++; if (evq[i].is_err) begin n_fail++; $display("FAIL loop_kind[%0d]: got frame_error want valid", i); end
        n_cmp++; if (evq[i].data !== exp_b[i]) begin n_fail++; $display("FAIL loop_data[%0d]: got %h want %h", i, evq[i].data, exp_b[i]); end
        n_cmp++; if (evq[i].cyc - exp_t[i] != LATENCY) begin n_fail++; $display("FAIL loop_latency[%0d]: got %0d want %0d", i, evq[i].cyc - exp_t[i], LATENCY); end
      end
    end
    last_good = exp_b[exp_b.size() - 1];
    n_cmp++; if (data_out !== last_good) begin n_fail++; $display("FAIL loop_hold: got %h want %h", data_out, last_good); end
  endtask

  task automatic test_false_start();
    int k = 0;
    evq.delete();
    rx = 1'b0;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_on: got %b want 1", busy); end
    rx = 1'b1;
    while (busy === 1'b1 && k < 6) begin
      tick();
      k++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_off: got %b want 0 within 6 clk", busy); end
    repeat (3 * BITP) tick();
    n_cmp++; if (evq.size() != 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d want 0", evq.size()); end
  endtask

  task automatic test_frame_error();
    int t0;
    evq.delete();
    send_frame(8'h3C, 1'b0, t0);
    rx = 1'b1;
    wait_events(1, 50);
    n_cmp++;
    if (evq.size() != 1) begin
      n_fail++;
      $display("FAIL ferr_count: got %0d strobes want 1", evq.size());
    end else begin
      n_cmp++; if (!evq[0].is_err) begin n_fail++; $display("FAIL ferr_kind: got valid want frame_error"); end
      n_cmp++; if (evq[0].cyc - t0 != LATENCY) begin n_fail++; $display("FAIL ferr_latency: got %0d want %0d", evq[0].cyc - t0, LATENCY); end
    end
    n_cmp++; if (data_out !== last_good) begin n_fail++; $display("FAIL ferr_hold: got %h want %h", data_out, last_good); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    evq.delete();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    wait_events(2, 150);
    n_cmp++;
    if (evq.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d strobes want 2", evq.size());
    end else begin
      n_cmp++; if (evq[0].is_err || evq[0].data !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got err=%b data=%h want valid 00", evq[0].is_err, evq[0].data); end
      n_cmp++; if (evq[1].is_err || evq[1].data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got err=%b data=%h want valid ff", evq[1].is_err, evq[1].data); end
      n_cmp++; if (evq[1].cyc - evq[0].cyc != 10 * BITP) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", evq[1].cyc - evq[0].cyc, 10 * BITP); end
    end
    last_good = 8'hFF;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int         t0;
    b = 8'h81;
    evq.delete();
    rx = 1'b0;
    repeat (BITP) tick();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BITP) tick();
    end
    rx = b[4];
    repeat (BITP / 2) tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_clear: got busy=%b data=%h want 0/00", busy, data_out); end
    reset = 1'b0;
    repeat (3 * BITP) tick();
    n_cmp++; if (evq.size() != 0) begin n_fail++; $display("FAIL rst_mid_strobes: got %0d want 0", evq.size()); end
    send_frame(b, 1'b1, t0);
    wait_events(1, 50);
    n_cmp++;
    if (evq.size() != 1) begin
      n_fail++;
      $display("FAIL rst_clean_count: got %0d strobes want 1", evq.size());
    end else begin
      n_cmp++; if (evq[0].is_err || evq[0].data !== b) begin n_fail++; $display("FAIL rst_clean_data: got err=%b data=%h want valid %h", evq[0].is_err, evq[0].data, b); end
    end
    last_good = b;
  endtask

  task automatic test_break();
    int t0;
    int t1;
    evq.delete();
    rx = 1'b0;
    t0 = cyc;
    repeat (30 * BITP) tick();
    rx = 1'b1;
    repeat (2 * BITP) tick();
    send_frame(8'h7E, 1'b1, t1);
    wait_events(2, 150);
    n_cmp++;
    if (evq.size() != 2) begin
      n_fail++;
      $display("FAIL break_count: got %0d strobes want 2", evq.size());
    end else begin
      n_cmp++; if (!evq[0].is_err || evq[0].cyc - t0 != LATENCY) begin n_fail++; $display("FAIL break_ferr: got err=%b at +%0d want frame_error at +%0d", evq[0].is_err, evq[0].cyc - t0, LATENCY); end
      n_cmp++; if (evq[1].is_err || evq[1].data !== 8'h7E) begin n_fail++; $display("FAIL break_next: got err=%b data=%h want valid 7e", evq[1].is_err, evq[1].data); end
    end
    last_good = 8'h7E;
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    logic       stop;
    int         t0;
    ev_t        exp_q[$];
    evq.delete();
    for (int i = 0; i < 10; i++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, t0);
      exp_q.push_back('{is_err: !stop, data: stop ? b : last_good, cyc: t0 + LATENCY});
      if (stop) last_good = b;
      rx = 1'b1;
      // After a low stop bit the line must go high before a new start can be seen.
      repeat (stop ? $urandom_range(0, 12) : $urandom_range(3, 12)) tick();
    end
    wait_events(exp_q.size(), 300);
    n_cmp++;
    if (evq.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d strobes want %0d", evq.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (evq[i].is_err != exp_q[i].is_err || evq[i].cyc != exp_q[i].cyc ||
            (!exp_q[i].is_err && evq[i].data !== exp_q[i].data)) begin
          n_fail++;
          $display("FAIL rand_frame[%0d]: got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                   i, evq[i].is_err, evq[i].data, evq[i].cyc, exp_q[i].is_err, exp_q[i].data, exp_q[i].cyc);
        end
      end
    end
    n_cmp++; if (data_out !== last_good) begin n_fail++; $display("FAIL rand_hold: got %h want %h", data_out, last_good); end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_loopback();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
